// File: rtl/ipv4_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ipv4_rx : strips and checks the IPv4 header, forwards payload    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ipv4_rx #(
  parameter int          DATA_W   = 16,
  parameter int          LEN_W    = 2,
  parameter logic [31:0] LOCAL_IP = 32'hC0A80102,
  parameter logic [7:0]  PROTO    = 8'd17
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              ip_cs_err_o,
  output logic              cancel_o
);

  localparam int          c_REM_W   = 16;
  localparam logic [15:0] c_HDR_LEN = 16'd20;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_HEAD = 4'b0010,
    S_DATA = 4'b0100,
    S_PAD  = 4'b1000
  } state_t;

  state_t              r_state;
  logic [3:0]          r_wcnt;
  logic                r_drop;
  logic                r_cs_err;
  logic                r_first;
  logic [15:0]         r_tot_len;
  logic [c_REM_W-1:0]  r_rem;
  logic [DATA_W-1:0]   r_acc;

  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_acc_next;
  logic                w_w0_bad;
  logic                w_hdr_bad;
  logic [c_REM_W-1:0]  w_len_ext;
  logic [LEN_W-1:0]    w_len_trim;
  logic [c_REM_W-1:0]  w_rem_next;
  logic                w_in_data;
  logic                w_in_pad;

  // One's-complement add: a single fold suffices since the sum never re-carries
  assign w_sum      = {1'b0, r_acc} + {1'b0, data_i};
  assign w_acc_next = w_sum[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, w_sum[DATA_W]};

  assign w_w0_bad = (data_i[15:12] != 4'd4) || (data_i[11:8] != 4'd5);

  always_comb begin
    w_hdr_bad = 1'b0;
    case (r_wcnt)
      4'd1:    w_hdr_bad = (data_i < c_HDR_LEN);
      4'd3:    w_hdr_bad = data_i[13] || (data_i[12:0] != 13'd0);
      4'd4:    w_hdr_bad = (data_i[7:0] != PROTO);
      4'd8:    w_hdr_bad = (data_i != LOCAL_IP[31:16]);
      4'd9:    w_hdr_bad = (data_i != LOCAL_IP[15:0]);
      default: w_hdr_bad = 1'b0;
    endcase
  end

  assign w_len_ext  = {{(c_REM_W-LEN_W){1'b0}}, len_i};
  assign w_len_trim = (r_rem < w_len_ext) ? r_rem[LEN_W-1:0] : len_i;
  assign w_rem_next = r_rem - {{(c_REM_W-LEN_W){1'b0}}, w_len_trim};

  assign w_in_data = (r_state == S_DATA);
  assign w_in_pad  = (r_state == S_PAD);

  assign valid_o     = w_in_data & valid_i & ~r_drop;
  assign start_o     = valid_o & r_first;
  assign data_o      = data_i;
  assign len_o       = w_len_trim;
  assign ip_cs_err_o = r_cs_err & valid_o;
  // Upstream abort, or the frame ended before Total Length bytes were seen
  assign cancel_o    = ~r_drop & ((cancel_i & (w_in_data | w_in_pad)) |
                                  (w_in_data & ~valid_i & (r_rem != '0)));

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state  <= S_IDLE;
      r_drop   <= 1'b0;
      r_cs_err <= 1'b0;
      r_first  <= 1'b0;
    end else if (cancel_i) begin
      r_state <= S_IDLE;
    end else if (valid_i && start_i) begin
      r_state <= S_HEAD;
      r_wcnt  <= 4'd1;
      r_drop  <= w_w0_bad;
      r_acc   <= data_i;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_HEAD: begin
          if (!valid_i) begin
            r_state <= S_IDLE;
          end else begin
            r_drop <= r_drop | w_hdr_bad;
            r_acc  <= w_acc_next;
            r_wcnt <= r_wcnt + 4'd1;
            if (r_wcnt == 4'd1)
              r_tot_len <= data_i;
            if (r_wcnt == 4'd9) begin
              r_cs_err <= (w_acc_next != 16'hFFFF);
              r_rem    <= r_tot_len - c_HDR_LEN;
              r_first  <= 1'b1;
              r_state  <= (r_tot_len == c_HDR_LEN) ? S_PAD : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (!valid_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem   <= w_rem_next;
            r_first <= 1'b0;
            if (w_rem_next == '0)
              r_state <= S_PAD;
          end
        end
        S_PAD: begin
          if (!valid_i)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
